// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment driver for NUM_DIGITS packed BCD digits.
// A shadow register captures the BCD word on load. A prescaler holds each digit
// for REFRESH_DIV cycles before moving to the next one. Segment and anode lines
// are active-low and registered, so they follow idx and shadow one cycle later.
// Leading zeros can be blanked; digit 0 is never blanked.
module bcd_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow;

   logic [3:0]              cur_digit;
   logic                    cur_blank;
   logic                    upper_zero;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   an_next;

   // Select the scanned digit and decide blanking. The loop walks from the most
   // significant digit downward, so upper_zero holds "this digit and every higher
   // digit are 0" at the point where the loop reaches the scanned digit.
   always_comb begin
      cur_digit  = 4'd0;
      cur_blank  = 1'b0;
      upper_zero = 1'b1;
      an_next    = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (shadow[4*i +: 4] != 4'd0) begin
            upper_zero = 1'b0;
         end
         if (IW'(i) == idx) begin
            cur_digit  = shadow[4*i +: 4];
            cur_blank  = blank_lz && (i != 0) && upper_zero;
            an_next[i] = 1'b0;
         end
      end
   end

   // Active-low segment encoding {g,f,e,d,c,b,a}. Non-BCD codes 10..15 show a dash.
   always_comb begin
      seg_next = 7'h3F;
      if (cur_blank) begin
         seg_next = 7'h7F;
      end else begin
         case (cur_digit)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h3F;
         endcase
      end
   end

   // Prescaler, scan index, shadow capture and output registers.
   // Reset overrides load and the scan advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         idx       <= '0;
         shadow    <= '0;
         seg       <= 7'h7F;
         an        <= '1;
      end else begin
         seg <= seg_next;
         an  <= an_next;
         if (load) begin
            shadow <= digits_in;
         end
         if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            idx       <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Testbench for bcd_display_mux. It drives two instances from the same inputs:
// one with dwell 4 and one with dwell 1.
// At each rising edge a reference model pushes the expected {seg,an} for each
// instance into a queue. A monitor pops each queue just after the edge and
// compares. The model describes the display with arithmetic: the number of edges
// since reset picks the digit, and a shift of the stored word decides blanking.
module tb_bcd_display_mux;

   localparam int N  = 4;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   digits_in;
   logic          load;
   logic          blank_lz;
   logic [6:0]    seg, seg_f;
   logic [N-1:0]  an, an_f;

   logic [10:0]   exp_q[$];
   logic [10:0]   expf_q[$];

   int            n_checks = 0;
   int            n_pass   = 0;

   // Model state: edges since reset release, and the word shown on the display.
   int            t_m;
   logic [15:0]   sh_m;

   bcd_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .seg(seg), .an(an)
   );

   bcd_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(1)) dut_fast (
      .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .seg(seg_f), .an(an_f)
   );

   // Clock generation
   always #5 clk = ~clk;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] tbl [0:9];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      if (d > 4'd9) return 7'h3F;
      return tbl[d];
   endfunction

   // Expected {seg,an} for the t-th edge after reset release.
   function automatic logic [10:0] model_out(input int rdiv, input int t,
                                             input logic [15:0] sh, input logic bl);
      int         k;
      logic [3:0] d;
      logic [6:0] s;
      logic [3:0] a;
      k = (t / rdiv) % N;
      d = 4'((sh >> (4 * k)) & 16'hF);
      if (bl && k > 0 && (sh >> (4 * k)) == 16'd0) s = 7'h7F;
      else s = seg_code(d);
      a = 4'hF;
      a[k] = 1'b0;
      return {s, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: predict the outputs for this edge from the state before the edge.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.push_back({7'h7F, 4'hF});
         expf_q.push_back({7'h7F, 4'hF});
         t_m  = 0;
         sh_m = 16'h0;
      end else begin
         exp_q.push_back(model_out(RD, t_m, sh_m, blank_lz));
         expf_q.push_back(model_out(1, t_m, sh_m, blank_lz));
         t_m++;
         if (load) sh_m = digits_in;
      end
   end

   // Monitor: compare both instances just after each edge, and check one-hot-low anodes.
   always @(posedge clk) begin
      logic [10:0] e;
      #1;
      if (exp_q.size() == 0) check("exp_q_empty", 32'd0, 32'd1);
      else begin
         e = exp_q.pop_front();
         check("seg", 32'(seg), 32'(e[10:4]));
         check("an", 32'(an), 32'(e[3:0]));
         if (e[3:0] != 4'hF) check("an_onehot", 32'($countones(~an)), 32'd1);
      end
      if (expf_q.size() == 0) check("expf_q_empty", 32'd0, 32'd1);
      else begin
         e = expf_q.pop_front();
         check("seg_fast", 32'(seg_f), 32'(e[10:4]));
         check("an_fast", 32'(an_f), 32'(e[3:0]));
      end
   end

   // Driver tasks. Inputs change on the falling edge.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] w, input logic bl);
      load      = 1'b1;
      digits_in = w;
      blank_lz  = bl;
      @(negedge clk);
      load      = 1'b0;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      for (int i = 0; i < N; i++)
         w[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      return w;
   endfunction

   // Stimulus: directed scenarios first, then a randomized phase.
   initial begin
      reset = 1'b1; load = 1'b0; blank_lz = 1'b0; digits_in = 16'h0;
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      // Load while digit 0 is still dwelling (the dwell has already started).
      idle(1);
      load_word(16'h0009, 1'b0);
      idle(20);
      load_word(16'h1234, 1'b0);
      idle(20);
      load_word(16'h0070, 1'b1);
      idle(16);
      blank_lz = 1'b0;
      idle(16);
      load_word(16'h0A05, 1'b1);
      idle(16);
      // Reset part way through the scan, with load also high.
      idle(9);
      load = 1'b1; digits_in = 16'h5555;
      do_reset(1);
      load = 1'b0;
      idle(18);
      // Load held high so the display follows digits_in on every cycle.
      load = 1'b1;
      for (int i = 0; i < 12; i++) begin
         digits_in = rand_word();
         @(negedge clk);
      end
      load = 1'b0;
      // Random phase
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            load = 1'($urandom_range(0, 1));
            digits_in = rand_word();
            do_reset($urandom_range(1, 3));
            load = 1'b0;
         end else if (r < 7) begin
            load_word(rand_word(), 1'($urandom_range(0, 1)));
         end else if (r < 9) begin
            blank_lz = ~blank_lz;
         end
         idle($urandom_range(0, 5));
      end
      idle(3);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("expf_q_drained", 32'(expf_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
